// File: rtl/fifo_bh_pkg.sv
// Shared helpers for the narrow-to-wide packing FIFO: width arithmetic and lane placement.
package fifo_bh_pkg;

    function automatic int clog2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    localparam int IN_W_DEFAULT  = 32;
    localparam int RATIO_DEFAULT = 8;
    localparam int OUT_W         = IN_W_DEFAULT * RATIO_DEFAULT;
    localparam int CNT_W         = clog2(RATIO_DEFAULT + 1);

    // Bit offset of a lane in the packed word; the first lane written goes to the top when msb_first.
    function automatic int lane_place(input int lane, input int ratio, input int in_w, input bit msb_first);
        return msb_first ? (ratio - 1 - lane) * in_w : lane * in_w;
    endfunction

endpackage

// File: rtl/fifo_bh_upsize_sc_if.sv
// Producer/consumer bus of the packing FIFO; master drives writes and pops, slave is the FIFO.
interface fifo_bh_upsize_sc_if
    import fifo_bh_pkg::*;
#(
    parameter int IN_W      = IN_W_DEFAULT,
    parameter int OUT_W     = fifo_bh_pkg::OUT_W,
    parameter int CNT_W     = fifo_bh_pkg::CNT_W,
    parameter int DEPTH_LG2 = 9
);
    logic                 wr_en;
    logic [IN_W-1:0]      din;
    logic                 flush;
    logic                 full;
    logic                 almost_full;
    logic                 rd_en;
    logic [OUT_W-1:0]     dout;
    logic [CNT_W-1:0]     dout_cnt;
    logic                 empty;
    logic                 valid;
    logic [DEPTH_LG2:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr_en, din, flush, rd_en,
        input  full, almost_full, dout, dout_cnt, empty, valid, count, overflow, underflow
    );

    modport slave (
        input  wr_en, din, flush, rd_en,
        output full, almost_full, dout, dout_cnt, empty, valid, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_bh_sdp_ram.sv
// Simple dual-port storage with a registered read port; the read register doubles as the FWFT output.
module fifo_bh_sdp_ram #(
    parameter int WIDTH   = 260,
    parameter int ENTRIES = 511,
    parameter int ADDR_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [ENTRIES];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read-before-write: a same-address read and write returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo_bh_upsize_sc.sv
// Narrow-to-wide packing FIFO: lanes are gathered into a word, stored, and presented first-word-fall-through.
module fifo_bh_upsize_sc
    import fifo_bh_pkg::*;
#(
    parameter int IN_W      = 32,
    parameter int RATIO     = 8,
    parameter int DEPTH     = 512,
    parameter int DEPTH_LG2 = 9,
    parameter int AF_MARGIN = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    fifo_bh_upsize_sc_if.slave   bus
);
    localparam int WORD_W   = IN_W * RATIO;
    localparam int LANE_W   = clog2(RATIO + 1);
    localparam int CNT_BITS = DEPTH_LG2 + 1;
    localparam int ENTRIES  = DEPTH - 1;
    localparam logic [CNT_BITS-1:0]  DEPTH_C   = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0]  AF_LEVEL  = CNT_BITS'(DEPTH - AF_MARGIN);
    localparam logic [LANE_W-1:0]    LAST_LANE = LANE_W'(RATIO - 1);
    localparam logic [DEPTH_LG2-1:0] LAST_ADDR = DEPTH_LG2'(ENTRIES - 1);

    logic [WORD_W-1:0]        pack_q, pack_next;
    logic [LANE_W-1:0]        lane_cnt, lanes_next;
    logic                     flush_pend;
    logic [DEPTH_LG2-1:0]     wr_ptr, rd_ptr;
    logic [CNT_BITS-1:0]      count_q;
    logic                     valid_q;
    logic                     overflow_q, underflow_q;
    logic                     full_w, wr_acc, pop, room, flush_req, commit, ram_rd;
    logic [WORD_W+LANE_W-1:0] ram_rdata;

    // Storage holds one word fewer than DEPTH, so pointers wrap at the last RAM entry.
    function automatic logic [DEPTH_LG2-1:0] ptr_inc(input logic [DEPTH_LG2-1:0] p);
        return (p == LAST_ADDR) ? '0 : p + 1'b1;
    endfunction

    // A same-cycle write is packed before any flush decision so it joins the closing word.
    always_comb begin
        full_w     = flush_pend | ((count_q == DEPTH_C) && (lane_cnt == LAST_LANE));
        wr_acc     = bus.wr_en & ~full_w;
        pop        = bus.rd_en & valid_q;
        room       = (count_q != DEPTH_C) | pop;
        flush_req  = bus.flush | flush_pend;
        lanes_next = lane_cnt + LANE_W'(wr_acc);
        pack_next  = pack_q;
        for (int i = 0; i < RATIO; i++) begin
            if (wr_acc && (lane_cnt == LANE_W'(i)))
                pack_next[lane_place(i, RATIO, IN_W, MSB_FIRST) +: IN_W] = bus.din;
        end
        commit = (wr_acc && (lane_cnt == LAST_LANE)) |
                 (flush_req && (lanes_next != '0) && room);
        ram_rd = (count_q != CNT_BITS'(valid_q)) && (!valid_q || bus.rd_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pack_q      <= '0;
            lane_cnt    <= '0;
            flush_pend  <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (commit) begin
                pack_q   <= '0;
                lane_cnt <= '0;
            end else if (wr_acc) begin
                pack_q   <= pack_next;
                lane_cnt <= lanes_next;
            end
            flush_pend <= flush_req && (lanes_next != '0) && !commit;
            if (commit) wr_ptr <= ptr_inc(wr_ptr);
            if (ram_rd) rd_ptr <= ptr_inc(rd_ptr);
            count_q <= count_q + CNT_BITS'(commit) - CNT_BITS'(pop);
            if (ram_rd)   valid_q <= 1'b1;
            else if (pop) valid_q <= 1'b0;
            overflow_q  <= overflow_q  | (bus.wr_en & full_w);
            underflow_q <= underflow_q | (bus.rd_en & ~valid_q);
        end
    end

    fifo_bh_sdp_ram #(
        .WIDTH   (WORD_W + LANE_W),
        .ENTRIES (ENTRIES),
        .ADDR_W  (DEPTH_LG2)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (commit),
        .waddr (wr_ptr),
        .wdata ({lanes_next, pack_next}),
        .re    (ram_rd),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    assign bus.dout        = ram_rdata[WORD_W-1:0];
    assign bus.dout_cnt    = ram_rdata[WORD_W +: LANE_W];
    assign bus.empty       = ~valid_q;
    assign bus.valid       = valid_q;
    assign bus.count       = count_q;
    assign bus.full        = full_w;
    assign bus.almost_full = (count_q >= AF_LEVEL);
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule
